rf_writeback_ctrl: RTL

//  Shares the single register-file write port among NUM_REQ writeback sources
//  (ALU, load unit, CSR/mul-div) using round-robin arbitration with a valid/ready handshake.

---
 rtl/rf_writeback_ctrl_pkg.sv | 15 +
 rtl/rf_writeback_ctrl_rr_arbiter.sv | 61 ++++++
 rtl/rf_writeback_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/rf_writeback_ctrl_pkg.sv
// Shared constants and types for the register-file writeback path.
package rf_writeback_ctrl_pkg;

    localparam int RISCV_WORD_WIDTH = 32;
    localparam int GP_REG_COUNT     = 32;
    localparam int GP_REG_AW        = $clog2(GP_REG_COUNT);

    typedef logic [GP_REG_AW-1:0] reg_addr_t;

    // Next round-robin position after granting index idx.
    function automatic int rr_next(input int idx, input int num_req);
        return (idx == num_req - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rf_writeback_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from req_i and the pointer,
// pointer moves to the slot after the winner whenever a grant is issued.
module rf_writeback_ctrl_rr_arbiter
    import rf_writeback_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_any_o,
    output logic [PW-1:0]      gnt_idx_o
);

    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      ptr_d;
    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      gnt_idx;
    logic               found;
    int                 idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr_q) + off) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found     = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = PW'(rr_next(int'(gnt_idx), NUM_REQ));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_o     = gnt;
    assign gnt_any_o = found;
    assign gnt_idx_o = gnt_idx;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_gnt_subset: assert property (@(posedge clk) disable iff (!rst_n) (gnt & ~req_i) == '0);

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Shares the register-file write port among writeback sources and tracks
// pending destinations so decode can stall on RAW/WAW hazards.
module rf_writeback_ctrl
    import rf_writeback_ctrl_pkg::*;
#(
    parameter int  NUM_REQ   = 3,
    parameter int  XLEN      = RISCV_WORD_WIDTH,
    parameter int  REG_COUNT = GP_REG_COUNT,
    localparam int AW        = $clog2(REG_COUNT),
    localparam int PW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      wb_valid_i,
    input  logic [NUM_REQ*AW-1:0]   wb_addr_i,
    input  logic [NUM_REQ*XLEN-1:0] wb_data_i,
    output logic [NUM_REQ-1:0]      wb_ready_o,
    output logic                    rf_we_o,
    output logic [AW-1:0]           rf_waddr_o,
    output logic [XLEN-1:0]         rf_wdata_o,
    input  logic                    issue_valid_i,
    input  logic [AW-1:0]           issue_rd_i,
    output logic                    issue_ready_o,
    input  logic [AW-1:0]           rs1_addr_i,
    input  logic [AW-1:0]           rs2_addr_i,
    output logic                    rs1_busy_o,
    output logic                    rs2_busy_o
);

    logic [NUM_REQ-1:0]   gnt;
    logic                 gnt_any;
    logic [PW-1:0]        gnt_idx;
    logic [AW-1:0]        sel_addr;
    logic [XLEN-1:0]      sel_data;

    logic                 rf_we_q,    rf_we_d;
    logic [AW-1:0]        rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;
    logic [REG_COUNT-1:0] busy_q,     busy_d;

    logic                 issue_ready;
    logic                 issue_set;

    rf_writeback_ctrl_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (wb_valid_i),
        .gnt_o     (gnt),
        .gnt_any_o (gnt_any),
        .gnt_idx_o (gnt_idx)
    );

    assign wb_ready_o = gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(gnt_idx) == i) begin
                sel_addr = wb_addr_i[i*AW +: AW];
                sel_data = wb_data_i[i*XLEN +: XLEN];
            end
        end
    end

    // x0 writes are acknowledged to the requester but never reach the register file.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (gnt_any) begin
            rf_we_d    = (sel_addr != '0);
            rf_waddr_d = sel_addr;
            rf_wdata_d = sel_data;
        end
    end

    assign issue_ready = !busy_q[issue_rd_i]
                       | (gnt_any && (sel_addr == issue_rd_i))
                       | (issue_rd_i == '0);
    assign issue_set   = issue_valid_i && issue_ready && (issue_rd_i != '0);

    // Clear first, then set: a new producer issued in the same cycle stays pending.
    always_comb begin
        busy_d = busy_q;
        if (gnt_any) begin
            busy_d[sel_addr] = 1'b0;
        end
        if (issue_set) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we_o       = rf_we_q;
    assign rf_waddr_o    = rf_waddr_q;
    assign rf_wdata_o    = rf_wdata_q;
    assign issue_ready_o = issue_ready;
    assign rs1_busy_o    = busy_q[rs1_addr_i] && !(gnt_any && (sel_addr == rs1_addr_i));
    assign rs2_busy_o    = busy_q[rs2_addr_i] && !(gnt_any && (sel_addr == rs2_addr_i));

endmodule
